// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the UART receiver          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_BIT    = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] data_len(input logic [1:0] dbn);
        case (dbn)
            DBITS_5: data_len = 4'd5;
            DBITS_6: data_len = 4'd6;
            DBITS_7: data_len = 4'd7;
            default: data_len = 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_if : line, configuration and holding-register signals        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_rx_if;
    logic       tick;
    logic       rx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;
    logic       rts_n;

    modport master (
        output tick, rx, data_bit_num, stop_bit_num, parity_en, parity_type, rx_read,
        input  rx_data, rx_done, rx_valid, parity_error, frame_error, overrun, rts_n
    );

    modport slave (
        input  tick, rx, data_bit_num, stop_bit_num, parity_en, parity_type, rx_read,
        output rx_data, rx_done, rx_valid, parity_error, frame_error, overrun, rts_n
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sync : 2-flop synchronizer, resets to the idle (high) level  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 16x oversampled UART receiver with parity/frame/overrun    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    rx_state_e  state_q,    state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;
    logic [1:0] dbn_q,      dbn_d;
    logic       sbn_q,      sbn_d;
    logic       pen_q,      pen_d;
    logic       ptype_q,    ptype_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       par_bad_q,  par_bad_d;
    logic       stop_bad_q, stop_bad_d;
    logic [7:0] data_q,     data_d;
    logic       done_q,     done_d;
    logic       valid_q,    valid_d;
    logic       perr_q,     perr_d;
    logic       ferr_q,     ferr_d;
    logic       ovr_q,      ovr_d;

    logic       w_rx;
    logic [3:0] w_len;
    logic [7:0] w_aligned;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.rx),
        .sync_o  (w_rx)
    );

    // Bits enter at the MSB, so a short frame sits in the upper bits until realigned.
    assign w_len     = data_len(dbn_q);
    assign w_aligned = shift_q >> (4'd8 - w_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            dbn_q      <= '0;
            sbn_q      <= 1'b0;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dbn_q      <= dbn_d;
            sbn_q      <= sbn_d;
            pen_q      <= pen_d;
            ptype_q    <= ptype_d;
            stop_cnt_q <= stop_cnt_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            data_q     <= data_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dbn_d      = dbn_q;
        sbn_d      = sbn_q;
        pen_d      = pen_q;
        ptype_d    = ptype_q;
        stop_cnt_d = stop_cnt_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        data_d     = data_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;

        if (bus.rx_read) valid_d = 1'b0;

        if (bus.tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_rx) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        stop_cnt_d = 1'b0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                        dbn_d      = bus.data_bit_num;
                        sbn_d      = bus.stop_bit_num;
                        pen_d      = bus.parity_en;
                        ptype_d    = bus.parity_type;
                    end
                end
                ST_START: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == MID_BIT) begin
                        tick_cnt_d = '0;
                        state_d    = w_rx ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        shift_d   = {w_rx, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if ({1'b0, bit_cnt_q} == w_len - 4'd1)
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        par_bad_d = (^w_aligned) ^ w_rx ^ ptype_q;
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        if (sbn_q && !stop_cnt_q) begin
                            stop_cnt_d = 1'b1;
                            stop_bad_d = ~w_rx;
                        end else begin
                            // Frame completion: errors are reported, never stall the receiver.
                            data_d  = w_aligned;
                            perr_d  = par_bad_q;
                            ferr_d  = stop_bad_q | ~w_rx;
                            ovr_d   = valid_q & ~bus.rx_read;
                            valid_d = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_done      = done_q;
    assign bus.rx_valid     = valid_q;
    assign bus.parity_error = perr_q;
    assign bus.frame_error  = ferr_q;
    assign bus.overrun      = ovr_q;
    assign bus.rts_n        = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx : directed + randomized frames against a frame-level model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] tdiv = '0;

    uart_rx_if u_if ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    // One tick every four clocks.
    always @(posedge clk) begin
        tdiv    <= tdiv + 2'd1;
        u_if.tick <= (tdiv == 2'd3);
    end

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    logic [7:0] exp_data;
    logic       exp_valid, exp_perr, exp_ferr, exp_ovr;
    int         exp_done;

    always @(negedge clk) if (u_if.rx_done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (u_if.tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        u_if.rx = b;
        wait_ticks(n);
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, ".data"},  32'(u_if.rx_data),      32'(exp_data));
        check_eq({tag, ".perr"},  32'(u_if.parity_error), 32'(exp_perr));
        check_eq({tag, ".ferr"},  32'(u_if.frame_error),  32'(exp_ferr));
        check_eq({tag, ".ovr"},   32'(u_if.overrun),      32'(exp_ovr));
        check_eq({tag, ".valid"}, 32'(u_if.rx_valid),     32'(exp_valid));
        check_eq({tag, ".rts_n"}, 32'(u_if.rts_n),        32'(exp_valid));
        check_eq({tag, ".ndone"}, 32'(done_cnt),          32'(exp_done));
    endtask

    // Sends one frame on the line and updates the expected holding-register state.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sbn,
                              input logic pen, input logic ptype, input logic flip,
                              input logic [1:0] slow, input logic scramble);
        logic [7:0] m;
        logic       last;
        int         len;
        len = 5 + int'(dbn);
        m   = 8'hFF >> (3 - int'(dbn));
        u_if.data_bit_num = dbn;
        u_if.stop_bit_num = sbn;
        u_if.parity_en    = pen;
        u_if.parity_type  = ptype;
        drive_bit(1'b0, 16);
        if (scramble) begin
            u_if.data_bit_num = 2'($urandom);
            u_if.stop_bit_num = 1'($urandom);
            u_if.parity_en    = 1'($urandom);
            u_if.parity_type  = 1'($urandom);
        end
        for (int i = 0; i < len; i++) drive_bit(d[i], 16);
        if (pen) drive_bit((^(d & m)) ^ ptype ^ flip, 16);
        if (sbn) drive_bit(~slow[0], 16);
        last = sbn ? slow[1] : slow[0];
        if (last) begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4);
        end else begin
            drive_bit(1'b1, 16);
        end
        exp_ovr   = exp_valid;
        exp_valid = 1'b1;
        exp_data  = d & m;
        exp_perr  = pen & flip;
        exp_ferr  = (sbn & slow[0]) | last;
        exp_done++;
        u_if.rx = 1'b1;
        wait_ticks(24);
    endtask

    task automatic do_read(input string tag);
        @(negedge clk) u_if.rx_read = 1'b1;
        @(negedge clk) u_if.rx_read = 1'b0;
        exp_valid = 1'b0;
        check_eq({tag, ".rd_valid"}, 32'(u_if.rx_valid), 32'(exp_valid));
        check_eq({tag, ".rd_rts_n"}, 32'(u_if.rts_n),    32'(exp_valid));
    endtask

    initial begin
        rst = 1'b1;
        u_if.rx = 1'b1;
        u_if.rx_read = 1'b0;
        u_if.data_bit_num = 2'b11;
        u_if.stop_bit_num = 1'b0;
        u_if.parity_en = 1'b0;
        u_if.parity_type = 1'b0;
        exp_data = '0; exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0; exp_done = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_frame("reset");

        send_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check_frame("a5_even");
        do_read("a5_even");

        send_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        check_frame("a5_odd");
        do_read("a5_odd");

        drive_bit(1'b0, 4);
        u_if.rx = 1'b1;
        wait_ticks(24);
        check_frame("glitch");

        send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        check_frame("b5_stoplow");
        do_read("b5_stoplow");

        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check_frame("ovr_first");
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check_frame("ovr_second");
        do_read("ovr_second");

        for (int k = 0; k < 30; k++) begin
            logic [1:0] slow;
            slow = '0;
            if ($urandom_range(9, 0) == 0) slow[0] = 1'b1;
            if ($urandom_range(9, 0) == 0) slow[1] = 1'b1;
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(9, 0) == 0), slow, 1'b1);
            check_frame($sformatf("rnd%0d", k));
            if ($urandom_range(9, 0) < 7) do_read($sformatf("rnd%0d", k));
        end

        // Load every status flag, then reset in the middle of a data bit.
        send_frame(8'h77, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        send_frame(8'h77, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        check_frame("pre_rst");
        u_if.data_bit_num = 2'b11;
        u_if.parity_en = 1'b0;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_data = '0; exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
        check_frame("mid_rst");
        u_if.rx = 1'b1;
        #20 rst = 1'b0;
        wait_ticks(24);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check_frame("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: tick  input  1  one-clk-wide enable pulse at 16x baud rate.
REQ-004 SHALL have: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have: data_bit_num  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-006 SHALL have: stop_bit_num  input  1  0=one stop bit, 1=two stop bits.
REQ-007 SHALL have: parity_en  input  1  1=parity bit present after data.
REQ-008 SHALL have: parity_type  input  1  0=even, 1=odd.
REQ-009 SHALL have: rx_read  input  1  one-cycle pulse; consumer has taken rx_data.
REQ-010 SHALL have: rx_data  output  8  received byte, LSB first on line, unused upper bits 0.
REQ-011 SHALL have: rx_done  output  1  one-clk pulse when a frame completes.
REQ-012 SHALL have: rx_valid  output  1  holding register full; high from rx_done until rx_read.
REQ-013 SHALL have: parity_error, frame_error, overrun  outputs  1 each  status of the last completed frame.
REQ-014 SHALL have: rts_n  output  1  flow control; equals rx_valid (high = not ready).

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter SHALL count tick pulses within a bit.
REQ-017 IDLE: synchronized rx low on a tick SHALL enter START with tick counter cleared.
REQ-018 START: at the 8th tick (counter=7) rx SHALL be resampled; high -> back to IDLE (glitch rejected, no flags); low -> DATA, counter cleared.
REQ-019 DATA/PARITY/STOP: each bit SHALL be sampled at the 16th tick (counter=15) after the previous sample point, i.e. bit centre.
REQ-020 DATA SHALL shift in LSB first for exactly 5/6/7/8 bits per data_bit_num; then PARITY if parity_en else STOP.
REQ-021 Parity check: XOR of data bits, parity bit and parity_type SHALL be 0; otherwise parity_error=1 for that frame.
REQ-022 STOP: each stop bit sampled low SHALL set frame_error; with stop_bit_num=1 both stop bits are checked.
REQ-023 Frame completion SHALL occur at the centre of the last stop bit: same clk cycle rx_data, parity_error, frame_error load, rx_done pulses, rx_valid sets, FSM returns to IDLE.
REQ-024 If rx_valid is already 1 at frame completion (rx_read not received in same cycle), overrun SHALL be 1 and rx_data SHALL be overwritten with the new frame.
REQ-025 rx_read and frame completion in the same cycle SHALL leave rx_valid=1 and overrun=0.
REQ-026 rx_read with rx_valid=0 SHALL have no effect.
REQ-027 Configuration inputs SHALL be sampled only while in IDLE; changes mid-frame have no effect on that frame.
REQ-028 Frames with errors SHALL still complete normally (rx_done, rx_valid set); errors SHALL not stall the FSM.
REQ-029 Logic SHALL act only on cycles where tick=1, except rx_read handling and synchronizer.

Reset
REQ-030 rst SHALL immediately force IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-031 Reset values: rx_data=0, rx_done=0, rx_valid=0, parity_error=0, frame_error=0, overrun=0, rts_n=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; reception resumes at the next falling edge after rst deasserts.

Structure
REQ-033 Package uart_pkg SHALL hold the rx state enum, OVERSAMPLE=16, mid-bit constant 7, and data_bit_num decode constants.
REQ-034 A sub-module uart_rx_sync (2-flop synchronizer, reset-to-1) SHALL be instantiated for rx.

Verification
REQ-035 0xA5, 8 bits, even parity (parity bit 0), 1 stop -> rx_data=0xA5, one rx_done pulse, all errors 0, rts_n=1.
REQ-036 Same frame with parity_type=1 -> rx_data=0xA5, parity_error=1, frame_error=0.
REQ-037 rx low for 4 ticks then high -> no rx_done, FSM in IDLE, rx_valid stays 0.
REQ-038 5-bit frame 0x15, no parity, stop bit driven low -> rx_data=0x15, frame_error=1.
REQ-039 Two frames 0x3C then 0xC3 with no rx_read -> overrun=1, rx_data=0xC3; rx_read then clears rx_valid and rts_n.
REQ-040 rst asserted mid DATA of a frame -> all outputs to reset values in that cycle; following clean 0x5A frame received correctly.
